// File: rtl/icd_cmd_engine.sv
// ICD command engine: parses SPI header/address/data frames and issues single-byte
// write/read cycles on the 24-bit system bus. It also produces the MISO bytes.
module icd_cmd_engine #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk6x,
  input  logic        resetn,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_hdr_en_i,
  input  logic        rx_db_en_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_en_o,
  output logic [23:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  output logic        bus_wr_o,
  output logic        bus_rd_o,
  input  logic [7:0]  bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        busy_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       OP_STATUS = 4'h0;
  localparam logic [3:0]       OP_WRITE  = 4'h1;
  localparam logic [3:0]       OP_READ   = 4'h2;

  typedef enum logic [2:0] {
    P_HDR, P_ADDR2, P_ADDR1, P_ADDR0, P_DATA, P_IGNORE
  } parse_state_e;

  typedef enum logic [1:0] {
    BUS_IDLE, BUS_WR, BUS_RD
  } bus_state_e;

  parse_state_e     parse_q, parse_d;
  bus_state_e       bus_q, bus_d;
  logic             is_read_q, is_read_d;
  logic             ainc_q, ainc_d;
  logic [23:0]      addr_q, addr_d;
  logic [23:0]      bus_addr_q, bus_addr_d;
  logic [7:0]       bus_wdata_q, bus_wdata_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             abort_q, abort_d;
  logic             tmo_err_q, tmo_err_d;
  logic             ovr_err_q, ovr_err_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_en_q, tx_en_d;

  logic       hdr_stb, db_stb, busy;
  logic       ack_done, tmo_done, cyc_done, discard, bus_free;
  logic       need_wr, need_rd, issue, overrun;
  logic [3:0] hdr_op;

  assign hdr_stb  = rx_hdr_en_i;
  assign db_stb   = rx_db_en_i & ~rx_hdr_en_i;
  assign hdr_op   = rx_byte_i[7:4];
  assign busy     = (bus_q != BUS_IDLE);
  assign ack_done = busy & bus_ack_i;
  assign tmo_done = busy & ~bus_ack_i & (tmo_cnt_q == CNT_LAST);
  assign cyc_done = ack_done | tmo_done;
  // A cycle that started before the latest header belongs to a dead frame.
  assign discard  = abort_q | hdr_stb;
  assign bus_free = ~busy | cyc_done;
  assign need_wr  = db_stb & (parse_q == P_DATA) & ~is_read_q;
  assign need_rd  = db_stb & is_read_q & ((parse_q == P_ADDR0) | (parse_q == P_DATA));
  assign issue    = (need_wr | need_rd) & bus_free;
  assign overrun  = (need_wr | need_rd) & ~bus_free;

  // State register for both FSMs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      parse_q <= P_HDR;
      bus_q   <= BUS_IDLE;
    end else begin
      parse_q <= parse_d;
      bus_q   <= bus_d;
    end
  end

  // Parser next state.
  // NOTE: each combinational output gets a default first so no latch is inferred.
  always_comb begin
    parse_d = parse_q;
    if (hdr_stb) begin
      parse_d = ((hdr_op == OP_WRITE) || (hdr_op == OP_READ)) ? P_ADDR2 : P_IGNORE;
    end else if (db_stb) begin
      case (parse_q)
        P_ADDR2: parse_d = P_ADDR1;
        P_ADDR1: parse_d = P_ADDR0;
        P_ADDR0: parse_d = P_DATA;
        default: parse_d = parse_q;
      endcase
    end
  end

  // Bus next state: completion is handled before a same-cycle new request.
  always_comb begin
    bus_d = bus_q;
    if (cyc_done) bus_d = BUS_IDLE;
    if (issue)    bus_d = need_wr ? BUS_WR : BUS_RD;
  end

  always_comb begin
    is_read_d   = is_read_q;
    ainc_d      = ainc_q;
    addr_d      = addr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    tmo_cnt_d   = tmo_cnt_q;
    abort_d     = abort_q;
    tmo_err_d   = tmo_err_q;
    ovr_err_d   = ovr_err_q;
    tx_byte_d   = tx_byte_q;
    tx_en_d     = 1'b0;

    if (hdr_stb) begin
      is_read_d = (hdr_op == OP_READ);
      ainc_d    = rx_byte_i[0];
    end

    if (cyc_done && !discard && ainc_q) addr_d = addr_q + 24'd1;
    if (db_stb) begin
      case (parse_q)
        P_ADDR2: addr_d[23:16] = rx_byte_i;
        P_ADDR1: addr_d[15:8]  = rx_byte_i;
        P_ADDR0: addr_d[7:0]   = rx_byte_i;
        default: ;
      endcase
    end

    if (busy) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    if (cyc_done) begin
      tmo_cnt_d = '0;
      abort_d   = 1'b0;
    end
    if (hdr_stb && busy && !cyc_done) abort_d = 1'b1;
    if (issue) begin
      tmo_cnt_d  = '0;
      bus_addr_d = addr_d;
      if (need_wr) bus_wdata_d = rx_byte_i;
    end

    // Status reports flags as they were before a STATUS header clears them.
    if (hdr_stb) begin
      tx_en_d   = 1'b1;
      tx_byte_d = {busy, 5'b0, tmo_err_q, ovr_err_q};
      if (hdr_op == OP_STATUS) begin
        tmo_err_d = 1'b0;
        ovr_err_d = 1'b0;
      end
    end else if (cyc_done && (bus_q == BUS_RD) && !abort_q) begin
      tx_en_d   = 1'b1;
      tx_byte_d = ack_done ? bus_rdata_i : 8'hFF;
    end
    if (tmo_done) tmo_err_d = 1'b1;
    if (overrun)  ovr_err_d = 1'b1;
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      is_read_q   <= 1'b0;
      ainc_q      <= 1'b0;
      addr_q      <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      tmo_cnt_q   <= '0;
      abort_q     <= 1'b0;
      tmo_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
      tx_byte_q   <= '0;
      tx_en_q     <= 1'b0;
    end else begin
      is_read_q   <= is_read_d;
      ainc_q      <= ainc_d;
      addr_q      <= addr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      tmo_cnt_q   <= tmo_cnt_d;
      abort_q     <= abort_d;
      tmo_err_q   <= tmo_err_d;
      ovr_err_q   <= ovr_err_d;
      tx_byte_q   <= tx_byte_d;
      tx_en_q     <= tx_en_d;
    end
  end

  // Outputs.
  always_comb begin
    bus_wr_o    = (bus_q == BUS_WR);
    bus_rd_o    = (bus_q == BUS_RD);
    busy_o      = busy;
    bus_addr_o  = bus_addr_q;
    bus_wdata_o = bus_wdata_q;
    tx_byte_o   = tx_byte_q;
    tx_en_o     = tx_en_q;
  end

endmodule
